// File: rtl/top_module_alu_if.sv
// Operand/opcode bus into the ALU and registered result/flag back out.
// master drives operands and opcode; slave is the ALU side.
interface top_module_alu_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic [2:0]       opc;
  logic [WIDTH-1:0] out;
  logic             overflow;

  modport master (output inp1, inp2, opc, input out, overflow);
  modport slave  (input inp1, inp2, opc, output out, overflow);
endinterface

// File: rtl/top_module_alu.sv
// Signed two's-complement ALU, eight ops, registered result and overflow flag.
// Latency: 1 cycle from operand sample to out/overflow.
// Backpressure: none; a new operation is accepted every cycle.
module top_module_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  top_module_alu_if.slave    alu
);

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_hi;
  logic               a_s;
  logic               b_s;
  logic               lt;
  logic [WIDTH-1:0]   res_nxt;
  logic               ovf_nxt;

  assign a_s   = alu.inp1[WIDTH-1];
  assign b_s   = alu.inp2[WIDTH-1];
  assign sum   = alu.inp1 + alu.inp2;
  assign diff  = alu.inp1 - alu.inp2;
  // Sign-extended unsigned multiply: the low 2*WIDTH bits equal the signed product.
  assign a_ext = {{WIDTH{a_s}}, alu.inp1};
  assign b_ext = {{WIDTH{b_s}}, alu.inp2};
  assign prod  = a_ext * b_ext;
  assign prod_hi = prod[2*WIDTH-1:WIDTH-1];
  assign lt    = $signed(alu.inp1) < $signed(alu.inp2);

  always_comb begin
    res_nxt = '0;
    ovf_nxt = 1'b0;
    case (alu.opc)
      3'b000: res_nxt = alu.inp1;
      3'b001: begin
        res_nxt = sum;
        ovf_nxt = (a_s == b_s) && (sum[WIDTH-1] != a_s);
      end
      3'b010: begin
        res_nxt = diff;
        ovf_nxt = (a_s != b_s) && (diff[WIDTH-1] != a_s);
      end
      3'b011: begin
        res_nxt = prod[WIDTH-1:0];
        // Product fits in WIDTH bits only if the top WIDTH+1 bits are all one sign.
        ovf_nxt = !((&prod_hi) || !(|prod_hi));
      end
      3'b100: res_nxt = alu.inp1 & alu.inp2;
      3'b101: res_nxt = alu.inp1 | alu.inp2;
      3'b110: res_nxt = alu.inp1 ^ alu.inp2;
      3'b111: res_nxt = {{(WIDTH-1){1'b0}}, lt};
      default: begin
        res_nxt = '0;
        ovf_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu.out      <= '0;
      alu.overflow <= 1'b0;
    end else begin
      alu.out      <= res_nxt;
      alu.overflow <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_top_module_alu.sv
// Self-checking bench for top_module_alu: directed vectors plus randomized ops
// against an integer-arithmetic reference model.
module tb_top_module_alu;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] prev_out;
  logic        prev_v;

  top_module_alu_if #(.WIDTH(16)) alu_bus ();

  top_module_alu #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .alu (alu_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        v;
  } vec_t;

  vec_t vecs [21] = '{
    '{3'd1, 16'h0004, 16'h0008, 16'h000C, 1'b0},
    '{3'd1, 16'h0020, 16'h0010, 16'h0030, 1'b0},
    '{3'd1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1},
    '{3'd2, 16'h0080, 16'h0004, 16'h007C, 1'b0},
    '{3'd2, 16'h8000, 16'h0080, 16'h7F80, 1'b1},
    '{3'd3, 16'h0040, 16'h0001, 16'h0040, 1'b0},
    '{3'd3, 16'h2000, 16'h4000, 16'h0000, 1'b1},
    '{3'd3, 16'hFFFF, 16'h0002, 16'hFFFE, 1'b0},
    '{3'd4, 16'h0010, 16'h0800, 16'h0000, 1'b0},
    '{3'd5, 16'h0008, 16'h8000, 16'h8008, 1'b0},
    '{3'd5, 16'h0040, 16'h8000, 16'h8040, 1'b0},
    '{3'd6, 16'h0002, 16'h2000, 16'h2002, 1'b0},
    '{3'd6, 16'h0010, 16'h0020, 16'h0030, 1'b0},
    '{3'd7, 16'h0080, 16'h0200, 16'h0001, 1'b0},
    '{3'd7, 16'h0000, 16'h4000, 16'h0001, 1'b0},
    '{3'd7, 16'h8000, 16'h0001, 16'h0001, 1'b0},
    '{3'd7, 16'h0005, 16'h0005, 16'h0000, 1'b0},
    '{3'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b1},
    '{3'd3, 16'h8000, 16'hFFFF, 16'h8000, 1'b1},
    '{3'd1, 16'h8000, 16'h0000, 16'h8000, 1'b0},
    '{3'd0, 16'h1234, 16'hABCD, 16'h1234, 1'b0}
  };

  logic [15:0] corners [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF,
                               16'h8000, 16'h00FF, 16'h4000, 16'hC000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer result, then wrap to 16 bits; overflow = out of signed range.
  function automatic void ref_alu(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic v);
    longint sx;
    longint sy;
    longint full;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    full = 0;
    r = 16'h0000;
    v = 1'b0;
    case (op)
      3'd0: full = sx;
      3'd1: full = sx + sy;
      3'd2: full = sx - sy;
      3'd3: full = sx * sy;
      default: full = 0;
    endcase
    if (op <= 3'd3) begin
      r = full[15:0];
      v = (full < -32768) || (full > 32767);
    end else if (op == 3'd4) r = x & y;
    else if (op == 3'd5) r = x | y;
    else if (op == 3'd6) r = x ^ y;
    else r = (sx < sy) ? 16'h0001 : 16'h0000;
  endfunction

  // Called just after a rising edge: drive, confirm output still holds, then check after next edge.
  task automatic do_op(input string tag, input logic r, input logic [2:0] op,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] exp_r, input logic exp_v);
    rst = r;
    alu_bus.opc  = op;
    alu_bus.inp1 = x;
    alu_bus.inp2 = y;
    #2;
    check_val({tag, "_hold"}, {15'd0, alu_bus.overflow, alu_bus.out}, {15'd0, prev_v, prev_out});
    @(posedge clk);
    #1;
    check_val({tag, "_out"}, {16'd0, alu_bus.out}, {16'd0, exp_r});
    check_val({tag, "_ovf"}, {31'd0, alu_bus.overflow}, {31'd0, exp_v});
    prev_out = exp_r;
    prev_v   = exp_v;
  endtask

  initial begin
    logic [15:0] er;
    logic        ev;
    logic [15:0] x;
    logic [15:0] y;
    logic [2:0]  op;
    logic        r;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    alu_bus.opc  = 3'd1;
    alu_bus.inp1 = 16'h7FFF;
    alu_bus.inp2 = 16'h0001;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_val("reset_out", {16'd0, alu_bus.out}, 32'd0);
    check_val("reset_ovf", {31'd0, alu_bus.overflow}, 32'd0);
    prev_out = 16'h0000;
    prev_v   = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("dir%0d", i), 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].v);

    // Reset wins over an overflowing add on the same edge, then normal operation resumes.
    do_op("midrst", 1'b1, 3'd1, 16'h7FFF, 16'h0001, 16'h0000, 1'b0);
    do_op("postrst", 1'b0, 3'd3, 16'h8000, 16'hFFFF, 16'h8000, 1'b1);

    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : 16'($urandom);
      y  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : 16'($urandom);
      if ($urandom_range(0, 4) == 0) y = x;
      r  = ($urandom_range(0, 19) == 0);
      ref_alu(op, x, y, er, ev);
      if (r) begin
        er = 16'h0000;
        ev = 1'b0;
      end
      do_op($sformatf("rnd%0d_op%0d", i, op), r, op, x, y, er, ev);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/top_module_alu.md
Name: top_module_alu

Overview:
- 16-bit signed two's-complement ALU with a registered result and overflow flag.
- Combinational datapath selects one of eight operations by a 3-bit opcode.
- Result and flag are captured on the rising clock edge.
- Sits as the arithmetic/logic execution block fed directly by operand and opcode buses.

Parameters:
- WIDTH, 16, operand/result width in bits (all tests use 16).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous active-high reset
- inp1  input  16  operand A, signed two's complement
- inp2  input  16  operand B, signed two's complement
- opc  input  3  operation select
- out  output  16  registered result
- overflow  output  1  registered signed-overflow flag

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset:
  - Evaluated only at the rising edge of clk.
  - Sets out=16'h0000 and overflow=0.
  - Has priority over any opcode.
  - A reset asserted mid-stream discards that cycle's computation.
- Latency: exactly 1 cycle.
  - inp1/inp2/opc sampled at rising edge N; out/overflow are valid after edge N.
  - Both hold until the next edge.
  - No handshake; a new operation is accepted every cycle.
- Opcode map (R = 16-bit result written to out, V = value written to overflow):
  - 000 pass: R=inp1, V=0.
  - 001 add: R=(inp1+inp2) mod 2^16. V=1 iff the operand signs are equal and the result sign differs.
  - 010 subtract: R=(inp1-inp2) mod 2^16. V=1 iff the operand signs differ and the result sign differs from inp1.
  - 011 multiply:
    - Full 32-bit signed product P; R=P[15:0].
    - V=1 iff P lies outside [-32768, 32767], i.e. P[31:15] is not all-equal.
  - 100 AND: R=inp1&inp2, V=0.
  - 101 OR: R=inp1|inp2, V=0.
  - 110 XOR: R=inp1^inp2, V=0.
  - 111 set-less-than (signed): R=16'h0001 if inp1<inp2 signed, else 16'h0000; V=0.
- Boundaries:
  - Arithmetic wraps modulo 2^16; no saturation.
  - -32768 - 1 gives R=16'h7FFF, V=1.
  - -32768 * -1 gives R=16'h8000, V=1.
  - Adding 0 never overflows.
  - Equal operands under 111 give R=0.
- Out-of-range opcode is impossible (3-bit field is fully decoded).
- No X propagation: every opcode drives every bit of out and overflow.

Test Plan:
- Reset, add, subtract: assert rst for 2 cycles -> out=0, overflow=0. Deassert; add 0x0004+0x0008 -> out=0x000C, V=0 one cycle later. Then 0x0020+0x0010 -> 0x0030, V=0. Then 0x7FFF+0x0001 -> 0x8000, V=1.
- Subtract: 0x0080-0x0004 -> 0x007C, V=0. 0x8000-0x0080 -> 0x7F80, V=1.
- Multiply: 0x0040*0x0001 -> 0x0040, V=0. 0x2000*0x4000 -> 0x0000, V=1. 0xFFFF*0x0002 -> 0xFFFE, V=0.
- Logic ops:
  - AND 0x0010&0x0800 -> 0x0000.
  - OR 0x0008|0x8000 -> 0x8008.
  - OR 0x0040|0x8000 -> 0x8040.
  - XOR 0x0002^0x2000 -> 0x2002.
  - XOR 0x0010^0x0020 -> 0x0030.
  - All with V=0.
- Compare (111): 0x0080 vs 0x0200 -> 0x0001. 0x0000 vs 0x4000 -> 0x0001. 0x8000 vs 0x0001 -> 0x0001 (signed). 0x0005 vs 0x0005 -> 0x0000.
- Reset mid-stream and back-to-back:
  - Reset mid-stream: an overflowing op is applied with rst=1 on the same edge -> out=0, V=0. The next op after release computes normally.
  - Back-to-back: opcodes issued on consecutive cycles each appear exactly one cycle later.
